// File: rtl/arm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// arm_mem_arbiter
//   Arbitrates one port of the dual-port ARM memory between two requesters:
//   requester 0 (core load/store path) and requester 1 (program loader/debug).
//   Round-robin on ties, req/ack handshake, one word per access. Read data and
//   the memory exception flag are captured into per-requester response
//   registers that are valid on the ack cycle and hold until the next ack.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req0/1, we0/1         request and direction (1 = write), held until ack
//   addr0/1, wdata0/1     byte address and write data of each requester
//   ack0/1                one-cycle completion pulse
//   rdata0/1, err0/1      registered read data / exception of the last access
//   mem_addr/wdata/we     shared memory port (zero outside ACCESS)
//   mem_rdata, mem_excpt  combinational read data / decode exception
//   busy, gnt_id          port in use, and which requester owns it
// ---------------------------------------------------------------------------
module arm_mem_arbiter #(
    parameter int   ADDR_W      = 32,
    parameter int   DATA_W      = 32,
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_excpt,
    output logic              busy,
    output logic              gnt_id
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              in_access;
    logic              other_req;
    logic              we_g;

    assign in_access = (state_q == ACCESS);
    // In RESP only the requester that was not just served may take the port;
    // the served requester still shows its old req for this one cycle.
    assign other_req = gnt_q ? req0 : req1;
    assign we_g      = gnt_q ? we1  : we0;

    // Response value for the served requester: an exception clears the data,
    // a clean write keeps the previous read data.
    function automatic logic [DATA_W-1:0] resp_data(input logic [DATA_W-1:0] prev,
                                                    input logic              we,
                                                    input logic              excpt,
                                                    input logic [DATA_W-1:0] rd);
        if (excpt)
            return '0;
        else if (we)
            return prev;
        else
            return rd;
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    if (req0 && req1)
                        gnt_d = ~last_q;
                    else
                        gnt_d = req1;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (other_req) begin
                    state_d = ACCESS;
                    gnt_d   = ~gnt_q;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d   = last_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        ack0_d   = in_access && !gnt_q;
        ack1_d   = in_access &&  gnt_q;
        if (in_access) begin
            last_d = gnt_q;
            if (!gnt_q) begin
                rdata0_d = resp_data(rdata0_q, we_g, mem_excpt, mem_rdata);
                err0_d   = mem_excpt;
            end else begin
                rdata1_d = resp_data(rdata1_q, we_g, mem_excpt, mem_rdata);
                err1_d   = mem_excpt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= FIRST_GRANT;
            last_q   <= ~FIRST_GRANT;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
        end
    end

    // The port is driven only in ACCESS; since state_q resets asynchronously,
    // mem_we falls the moment rst rises, so an in-flight write never commits.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (in_access) begin
            mem_addr  = gnt_q ? addr1  : addr0;
            mem_wdata = gnt_q ? wdata1 : wdata0;
            mem_we    = we_g;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign busy   = (state_q != IDLE);
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
module tb_arm_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, mem_we, mem_excpt, busy, gnt_id;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_GRANT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_excpt(mem_excpt),
        .busy(busy), .gnt_id(gnt_id)
    );

    // Memory model: 64 words mapped at 0x1000_0000, everything else excepts.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_init = 1'b1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hDEADBEEF;
            2:       return 32'h55AA55AA;
            3:       return 32'h0BADF00D;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    function automatic logic mapped(input logic [31:0] a);
        return a[31:8] == 24'h100000;
    endfunction

    assign mem_excpt = !mapped(mem_addr);
    assign mem_rdata = mapped(mem_addr) ? mem[mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_we && !mem_excpt) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: {err, rdata} expected per requester, in issue order.
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [31:0] exp_rd [2];
    logic [32:0] mon_e0, mon_e1;

    always @(negedge clk) begin
        if (!rst && ack0) begin
            check("ack0_pending", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                mon_e0 = q0.pop_front();
                check("rdata0", rdata0, mon_e0[31:0]);
                check("err0", 32'(err0), 32'(mon_e0[32]));
            end
        end
        if (!rst && ack1) begin
            check("ack1_pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                mon_e1 = q1.pop_front();
                check("rdata1", rdata1, mon_e1[31:0]);
                check("err1", 32'(err1), 32'(mon_e1[32]));
            end
        end
    end

    task automatic issue(input int g, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic expect_ack);
        logic [31:0] r;
        logic        in;
        in = mapped(a);
        if (expect_ack) begin
            if (!we) r = in ? ref_mem[a[7:2]] : 32'h0;
            else     r = in ? exp_rd[g] : 32'h0;
            exp_rd[g] = r;
            if (we && in) ref_mem[a[7:2]] = d;
            if (g == 0) q0.push_back({!in, r});
            else        q1.push_back({!in, r});
        end
        if (g == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    // Waits (bounded) for ack of requester g; counts cycles, busy cycles,
    // mem_we cycles and changes of that requester's rdata before the ack.
    task automatic wait_ack(input int g, output int n, output int nbusy,
                            output int nwe, output int nchg);
        logic [31:0] r0;
        logic        got;
        r0 = (g != 0) ? rdata1 : rdata0;
        n = 0; nbusy = 0; nwe = 0; nchg = 0; got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (busy)   nbusy++;
            if (mem_we) nwe++;
            got = (g != 0) ? ack1 : ack0;
            if (!got && (((g != 0) ? rdata1 : rdata0) !== r0)) nchg++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ack0"},   32'(ack0), 32'd0);
        check({tag, "_ack1"},   32'(ack1), 32'd0);
        check({tag, "_rdata0"}, rdata0, 32'd0);
        check({tag, "_rdata1"}, rdata1, 32'd0);
        check({tag, "_err0"},   32'(err0), 32'd0);
        check({tag, "_err1"},   32'(err1), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_gnt"},    32'(gnt_id), 32'd0);
        check({tag, "_we"},     32'(mem_we), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, nw, nc, id;
        logic [31:0] held;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        exp_rd[0] = '0; exp_rd[1] = '0;

        do_reset();
        mem_init = 1'b0;
        check_reset_state("rst1");

        // 1: read 0x1000_0000
        @(posedge clk); #1 issue(0, 1'b0, 32'h1000_0000, 32'h0, 1'b1);
        wait_ack(0, n, nb, nw, nc);
        check("t1_latency", 32'(n), 32'd3);
        check("t1_busy_cycles", 32'(nb), 32'd2);
        check("t1_we_cycles", 32'(nw), 32'd0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        check("t1_idle_after", 32'(busy), 32'd0);

        // 2: write then read back
        @(posedge clk); #1 issue(0, 1'b1, 32'h1000_0004, 32'h1234_5678, 1'b1);
        wait_ack(0, n, nb, nw, nc);
        check("t2_wr_latency", 32'(n), 32'd3);
        check("t2_we_cycles", 32'(nw), 32'd1);
        check("t2_mem_word", mem[1], 32'h1234_5678);
        @(posedge clk); #1 issue(0, 1'b0, 32'h1000_0004, 32'h0, 1'b1);
        wait_ack(0, n, nb, nw, nc);
        check("t2_rd_we_cycles", 32'(nw), 32'd0);
        @(posedge clk); #1 req0 = 1'b0;

        // 3: simultaneous continuous requests alternate 0,1,0,1
        do_reset();
        check_reset_state("rst2");
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h1000_0004, 32'h0, 1'b1);
        issue(1, 1'b0, 32'h1000_000C, 32'h0, 1'b1);
        issue(0, 1'b0, 32'h1000_0004, 32'h0, 1'b1);
        issue(1, 1'b0, 32'h1000_000C, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n = 0; nb = 0; id = -1;
            while (id < 0 && n < 12) begin
                @(negedge clk);
                n++;
                if (!busy) nb++;
                if (ack0) id = 0;
                else if (ack1) id = 1;
            end
            check($sformatf("t3_order%0d", k), 32'(id), 32'(k % 2));
            if (k > 0) begin
                check($sformatf("t3_spacing%0d", k), 32'(n), 32'd2);
                check($sformatf("t3_noidle%0d", k), 32'(nb), 32'd0);
            end
            if (k == 2) begin @(posedge clk); #1 req0 = 1'b0; end
            if (k == 3) begin @(posedge clk); #1 req1 = 1'b0; end
        end
        @(negedge clk);
        check("t3_idle_after", 32'(busy), 32'd0);

        // 4: unmapped read and write on requester 1
        @(posedge clk); #1 issue(1, 1'b0, 32'h2000_0000, 32'h0, 1'b1);
        wait_ack(1, n, nb, nw, nc);
        check("t4_rd_latency", 32'(n), 32'd3);
        @(posedge clk); #1 issue(1, 1'b1, 32'h2000_0000, 32'h7777_7777, 1'b1);
        wait_ack(1, n, nb, nw, nc);
        check("t4_wr_latency", 32'(n), 32'd3);
        @(posedge clk); #1 req1 = 1'b0;
        check("t4_mem_word0", mem[0], ref_mem[0]);

        // 5: reset during the ACCESS cycle of a write
        @(posedge clk); #1 issue(0, 1'b1, 32'h1000_0008, 32'hCAFE_F00D, 1'b0);
        @(posedge clk); #1;
        check("t5_we_in_access", 32'(mem_we), 32'd1);
        check("t5_addr_in_access", mem_addr, 32'h1000_0008);
        #1 rst = 1'b1;
        #1;
        check("t5_we_dropped", 32'(mem_we), 32'd0);
        check("t5_busy_dropped", 32'(busy), 32'd0);
        req0 = 1'b0; we0 = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(posedge clk); #1;
        check("t5_word_kept", mem[2], ref_mem[2]);
        check_reset_state("rst3");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_ack0", 32'(ack0), 32'd0);

        // 6: requester 1 alone, three back-to-back reads
        @(posedge clk); #1 issue(1, 1'b0, 32'h1000_0000, 32'h0, 1'b1);
        wait_ack(1, n, nb, nw, nc);
        check("t6_first_latency", 32'(n), 32'd3);
        for (int k = 0; k < 2; k++) begin
            held = rdata1;
            @(posedge clk); #1;
            if (k == 0) issue(1, 1'b0, 32'h1000_0004, 32'h0, 1'b1);
            else        issue(1, 1'b0, 32'h1000_000C, 32'h0, 1'b1);
            check($sformatf("t6_hold_at_issue%0d", k), rdata1, held);
            wait_ack(1, n, nb, nw, nc);
            check($sformatf("t6_spacing%0d", k), 32'(n), 32'd3);
            check($sformatf("t6_hold%0d", k), 32'(nc), 32'd0);
        end
        @(posedge clk); #1 req1 = 1'b0;

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
